branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Branch-resolution controller for the pipelined RV32 core; sits beside the EX-stage branch comparator.
//  Takes the comparator's taken flag for the instruction in EX and detects mispredictions.
//  Issues a registered PC redirect and flushes IF/ID and ID/EX for a fixed number of cycles.
//  Keeps 32-bit branch and mispredict counters; can optionally add a 2-bit dynamic predictor (BHT_EN).
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush is held after a redirect; legal range 1..7
//  BHT_ENTRIES   16  predictor entries, power of 2, 2..256; used only with BHT_EN
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  rst            in   1   synchronous reset, active-high
//  ex_valid       in   1   EX holds a real (non-bubble) instruction
//  ex_stall       in   1   pipeline stalled this cycle; EX instruction not retiring
//  ex_opcode      in   7   opcode of EX instruction
//  ex_funct3      in   3   funct3 of EX instruction
//  ex_pc          in   32  PC of EX instruction
//  ex_target      in   32  computed branch/jump target of EX instruction
//  cmp_taken      in   1   taken flag from the comparator
//  ex_pred_taken  in   1   prediction carried down the pipe for the EX instruction
//  id_pc          in   32  PC of the ID instruction (predictor lookup)
//  id_pred_taken  out  1   prediction for the ID instruction (combinational)
//  redirect_valid out  1   one-cycle pulse: load redirect_pc into PC
//  redirect_pc    out  32  PC to fetch next
//  flush          out  1   squash IF/ID and ID/EX contents
//  br_count       out  32  resolved control-flow instructions
//  mis_count      out  32  mispredictions
// BEHAVIOUR
//  - Opcodes: JAL=1101111, BRANCH=1100011. JAL is always taken.
//  - BRANCH: taken = cmp_taken, but only for funct3 000 (BEQ) or 100 (BLT).
//  - BRANCH with any other funct3 resolves not-taken; cmp_taken is ignored.
//  - resolve = ex_valid & ~ex_stall & state==RUN & opcode in {JAL, BRANCH}.
//  - mispredict = resolve & (taken != pred); pred is ex_pred_taken with BHT_EN, else 0.
//  - FSM states RUN and FLUSH. Reset enters RUN.
//  - RUN -> FLUSH on mispredict at edge t. Registered outputs, valid in cycle t+1:
//    - redirect_valid=1 for exactly one cycle.
//    - redirect_pc = taken ? ex_target : ex_pc+4 (mod 2^32, wraps).
//    - flush=1, flush counter loaded with FLUSH_CYCLES-1.
//  - FLUSH: flush=1 and the counter decrements every cycle, regardless of ex_stall.
//  - FLUSH -> RUN after the cycle in which the counter is 0. Flush lasts exactly FLUSH_CYCLES cycles.
//  - While in FLUSH, all EX inputs are ignored: no resolve, no counter or predictor updates.
//  - br_count +1 on each resolve; mis_count +1 on each mispredict. Both wrap 2^32-1 -> 0.
//  - A stalled EX (ex_stall=1) never resolves. The same instruction resolves once, in its unstalled cycle.
//  - Reset values: redirect_valid=0, redirect_pc=0, flush=0, counters=0, state=RUN.
//  - Reset asserted mid-flush returns to RUN with all outputs 0 on the next cycle.
// CONFIGURATION
//  Macro BHT_EN.
//  - Defined: BHT_ENTRIES x 2-bit saturating counters, all reset to 01 (weakly not-taken).
//    - Index = pc[log2(BHT_ENTRIES)+1:2].
//    - id_pred_taken = counter[idx(id_pc)][1] for any instruction; decoding in ID qualifies its use.
//    - Update on resolve of a BRANCH only (JAL not updated): increment if taken, decrement if not, saturate at 00/11.
//    - Same-cycle lookup and update of one index: lookup returns the pre-update value.
//  - Undefined: no table; id_pred_taken=0; ex_pred_taken ignored (static not-taken).
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, state RUN. Repeat with reset asserted mid-flush: same result.
//  2. BEQ: ex_pc=0x100, ex_target=0x140, cmp_taken=1, pred=0.
//     -> next cycle redirect_valid=1, redirect_pc=0x140, flush=1 for 2 cycles; mis_count=1, br_count=1.
//  3. BLT not taken, pred=0 -> no redirect, flush=0, br_count+1. Same with funct3=001, cmp_taken=1 -> not-taken, no redirect.
//  4. JAL resolves while ex_stall=1 for 3 cycles, then ex_stall=0.
//     -> exactly one redirect, in the cycle after the unstall; br_count+1 only once.
//  5. Mispredict, then ex_valid=1 with cmp_taken=1 during both flush cycles -> ignored; one redirect total.
//     Also preset br_count=0xFFFFFFFF and resolve -> wraps to 0.
//  6. BHT_EN: BEQ at pc 0x200 taken 3 times -> counter 11, id_pred_taken=1 for id_pc=0x200.
//     Then resolve with ex_pred_taken=1, not taken -> redirect_pc=0x204, counter 10.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// EX-stage branch resolution bus between the pipeline (master) and branch_ctrl (slave).
// The pipeline drives the EX/ID fields; branch_ctrl returns prediction, redirect, flush and counters.
interface branch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            ex_valid;
  logic            ex_stall;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            cmp_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] id_pc;
  logic            id_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [XLEN-1:0] br_count;
  logic [XLEN-1:0] mis_count;

  modport master (
    output ex_valid, ex_stall, ex_opcode, ex_funct3, ex_pc, ex_target,
           cmp_taken, ex_pred_taken, id_pc,
    input  id_pred_taken, redirect_valid, redirect_pc, flush, br_count, mis_count
  );

  modport slave (
    input  ex_valid, ex_stall, ex_opcode, ex_funct3, ex_pc, ex_target,
           cmp_taken, ex_pred_taken, id_pc,
    output id_pred_taken, redirect_valid, redirect_pc, flush, br_count, mis_count
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch-resolution controller: detects EX-stage mispredictions, issues a PC redirect and a
// fixed-length IF/ID + ID/EX flush. Optional 2-bit dynamic predictor enabled by macro BHT_EN.
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BHT_ENTRIES  = 16
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned FCNT_W = 3;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BLT    = 3'b100;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   br_count_q, br_count_d;
  logic [XLEN-1:0]   mis_count_q, mis_count_d;

  logic is_jal;
  logic is_branch;
  logic taken;
  logic resolve;
  logic pred;
  logic mispredict;

  // Decode and resolve the EX instruction; only BEQ/BLT can be taken among branches.
  always_comb begin
    is_jal     = (bus.ex_opcode == OP_JAL);
    is_branch  = (bus.ex_opcode == OP_BRANCH);
    taken      = is_jal |
                 (is_branch & bus.cmp_taken &
                  ((bus.ex_funct3 == F3_BEQ) | (bus.ex_funct3 == F3_BLT)));
    resolve    = bus.ex_valid & ~bus.ex_stall & (state_q == ST_RUN) & (is_jal | is_branch);
    mispredict = resolve & (taken != pred);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    br_count_d       = br_count_q + XLEN'(resolve);
    mis_count_d      = mis_count_q + XLEN'(mispredict);

    unique case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d          = ST_FLUSH;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));
          flush_d          = 1'b1;
          fcnt_d           = FCNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        // Counter value 0 marks the last flush cycle; EX inputs are ignored throughout.
        if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d  = fcnt_q - FCNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      fcnt_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      br_count_q       <= '0;
      mis_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      br_count_q       <= br_count_d;
      mis_count_q      <= mis_count_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.br_count       = br_count_q;
  assign bus.mis_count      = mis_count_q;

`ifdef BHT_EN
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] id_idx;
  logic             unused_id_pc;

  assign ex_idx             = bus.ex_pc[IDX_W+1:2];
  assign id_idx             = bus.id_pc[IDX_W+1:2];
  assign pred               = bus.ex_pred_taken;
  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign bus.id_pred_taken  = bht_q[id_idx][1];
  assign unused_id_pc       = ^bus.id_pc;

  // Saturating 2-bit counter update, conditional branches only.
  always_comb begin
    bht_d = bht_q;
    if (resolve && is_branch) begin
      if (taken && (bht_q[ex_idx] != 2'b11)) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else if (!taken && (bht_q[ex_idx] != 2'b00)) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bht_inputs;

  // Static not-taken: the carried prediction and ID lookup have no effect.
  assign pred              = 1'b0;
  assign bus.id_pred_taken = 1'b0;
  assign unused_bht_inputs = ^{bus.id_pc, bus.ex_pred_taken, BHT_ENTRIES[0]};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed table, multi-cycle corner sequences and a
// randomized run against a behavioural model. Predictor checks are compiled in with BHT_EN.
module tb_branch_ctrl;
  localparam int unsigned FC   = 2;
  localparam int unsigned NBHT = 16;

  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_ctrl_if bus ();

  branch_ctrl #(
    .FLUSH_CYCLES (FC),
    .BHT_ENTRIES  (NBHT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic        st;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        cmp;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [31:0] e_br;
    logic [31:0] e_mis;
  } vec_t;

  vec_t tbl [12];

  logic [31:0] exp_br;
  logic [31:0] exp_mis;

  // Behavioural model state: remaining flush cycles (0 = running), outputs, counters, predictor.
  int          m_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  int          m_bht [NBHT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic cmp,
                       input logic pr);
    bus.ex_valid      = v;
    bus.ex_stall      = st;
    bus.ex_opcode     = op;
    bus.ex_funct3     = f3;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.cmp_taken     = cmp;
    bus.ex_pred_taken = pr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    exp_br  = 32'h0;
    exp_mis = 32'h0;
  endtask

  task automatic chk_zero(input string tag);
    chk_b({tag, ".redirect_valid"}, bus.redirect_valid, 1'b0);
    chk({tag, ".redirect_pc"}, bus.redirect_pc, 32'h0);
    chk_b({tag, ".flush"}, bus.flush, 1'b0);
    chk({tag, ".br_count"}, bus.br_count, 32'h0);
    chk({tag, ".mis_count"}, bus.mis_count, 32'h0);
  endtask

  task automatic model_reset();
    m_left = 0;
    m_rv   = 1'b0;
    m_rpc  = 32'h0;
    m_br   = 32'h0;
    m_mis  = 32'h0;
    for (int i = 0; i < int'(NBHT); i++) m_bht[i] = 1;
  endtask

  // One rising edge of the model, evaluated from the inputs currently on the bus.
  task automatic model_step();
    bit is_cf, tk, res, pr, mis;
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    is_cf = (bus.ex_opcode == OP_JAL) || (bus.ex_opcode == OP_BR);
    tk    = (bus.ex_opcode == OP_JAL) ||
            ((bus.ex_opcode == OP_BR) && bus.cmp_taken &&
             (bus.ex_funct3 == 3'd0 || bus.ex_funct3 == 3'd4));
    res   = bus.ex_valid && !bus.ex_stall && (m_left == 0) && is_cf;
`ifdef BHT_EN
    pr = bus.ex_pred_taken;
`else
    pr = 1'b0;
`endif
    mis = res && (tk != pr);
    if (res) m_br = m_br + 32'd1;
    if (mis) m_mis = m_mis + 32'd1;
    idx = int'((bus.ex_pc >> 2) % NBHT);
    if (res && bus.ex_opcode == OP_BR) begin
      if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
      else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
    end
    if (m_left > 0)  m_left = m_left - 1;
    else if (mis)    m_left = int'(FC);
    m_rv = mis;
    if (mis) m_rpc = tk ? bus.ex_target : bus.ex_pc + 32'd4;
  endtask

  function automatic logic model_id_pred(input logic [31:0] pc);
`ifdef BHT_EN
    return m_bht[int'((pc >> 2) % NBHT)] >= 2;
`else
    return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_pc = 32'h0;
    idle();

    // Directed table: {v, stall, opcode, funct3, pc, target, cmp, exp_rv, exp_rpc, d_br, d_mis}
    tbl[0]  = '{1'b1, 1'b0, OP_BR,  3'b000, 32'h0000_0100, 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0140, 32'd1, 32'd1};
    tbl[1]  = '{1'b1, 1'b0, OP_BR,  3'b100, 32'h0000_0300, 32'h0000_0340, 1'b0, 1'b0, 32'h0,         32'd1, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, OP_BR,  3'b001, 32'h0000_0310, 32'h0000_0350, 1'b1, 1'b0, 32'h0,         32'd1, 32'd0};
    tbl[3]  = '{1'b1, 1'b0, OP_BR,  3'b100, 32'h0000_0400, 32'h0000_0380, 1'b1, 1'b1, 32'h0000_0380, 32'd1, 32'd1};
    tbl[4]  = '{1'b1, 1'b0, OP_JAL, 3'b000, 32'h0000_0500, 32'h0000_0600, 1'b0, 1'b1, 32'h0000_0600, 32'd1, 32'd1};
    tbl[5]  = '{1'b1, 1'b0, OP_ALU, 3'b000, 32'h0000_0520, 32'h0000_0700, 1'b1, 1'b0, 32'h0,         32'd0, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, OP_JAL, 3'b000, 32'h0000_0540, 32'h0000_0700, 1'b1, 1'b0, 32'h0,         32'd0, 32'd0};
    tbl[7]  = '{1'b1, 1'b1, OP_JAL, 3'b000, 32'h0000_0560, 32'h0000_0700, 1'b1, 1'b0, 32'h0,         32'd0, 32'd0};
    tbl[8]  = '{1'b1, 1'b0, OP_BR,  3'b000, 32'h0000_0580, 32'h0000_0700, 1'b0, 1'b0, 32'h0,         32'd1, 32'd0};
    tbl[9]  = '{1'b1, 1'b0, OP_BR,  3'b101, 32'h0000_05A0, 32'h0000_0700, 1'b1, 1'b0, 32'h0,         32'd1, 32'd0};
    tbl[10] = '{1'b1, 1'b0, OP_BR,  3'b111, 32'h0000_05C0, 32'h0000_0700, 1'b1, 1'b0, 32'h0,         32'd1, 32'd0};
    tbl[11] = '{1'b1, 1'b0, OP_JAL, 3'b000, 32'hFFFF_FF00, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0010, 32'd1, 32'd1};

    // Reset state.
    do_reset();
    chk_zero("reset");

    // Reset asserted mid-flush returns to RUN with outputs cleared.
    drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h100, 32'h140, 1'b1, 1'b0);
    step();
    chk_b("midflush.pre_rv", bus.redirect_valid, 1'b1);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midflush_reset");
    drive(1'b1, 1'b0, OP_JAL, 3'b000, 32'h10, 32'h80, 1'b0, 1'b0);
    step();
    chk_b("after_reset.rv", bus.redirect_valid, 1'b1);
    chk("after_reset.rpc", bus.redirect_pc, 32'h80);
    idle();
    repeat (FC) step();

    // Table-driven single instructions from a running state.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].op, tbl[i].f3, tbl[i].pc, tbl[i].tgt, tbl[i].cmp, 1'b0);
      step();
      exp_br  = exp_br + tbl[i].e_br;
      exp_mis = exp_mis + tbl[i].e_mis;
      chk_b($sformatf("tbl%0d.rv", i), bus.redirect_valid, tbl[i].e_rv);
      chk_b($sformatf("tbl%0d.flush", i), bus.flush, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d.rpc", i), bus.redirect_pc, tbl[i].e_rpc);
      chk($sformatf("tbl%0d.br", i), bus.br_count, exp_br);
      chk($sformatf("tbl%0d.mis", i), bus.mis_count, exp_mis);
      idle();
      repeat (FC) step();
      chk_b($sformatf("tbl%0d.flush_end", i), bus.flush, 1'b0);
    end

    // Stalled JAL resolves once, in the cycle after it unstalls.
    do_reset();
    drive(1'b1, 1'b1, OP_JAL, 3'b000, 32'h700, 32'h800, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_b($sformatf("stall%0d.rv", k), bus.redirect_valid, 1'b0);
      chk($sformatf("stall%0d.br", k), bus.br_count, 32'h0);
    end
    bus.ex_stall = 1'b0;
    step();
    chk_b("unstall.rv", bus.redirect_valid, 1'b1);
    chk("unstall.rpc", bus.redirect_pc, 32'h800);
    chk("unstall.br", bus.br_count, 32'h1);
    idle();
    for (int k = 0; k < int'(FC); k++) begin
      step();
      chk_b($sformatf("unstall_tail%0d.rv", k), bus.redirect_valid, 1'b0);
      chk_b($sformatf("unstall_tail%0d.flush", k), bus.flush, (k < int'(FC) - 1));
    end
    chk("unstall_tail.br", bus.br_count, 32'h1);

    // EX activity during the flush window is ignored.
    do_reset();
    drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h900, 32'h980, 1'b1, 1'b0);
    step();
    chk_b("flushwin.rv", bus.redirect_valid, 1'b1);
    chk("flushwin.rpc", bus.redirect_pc, 32'h980);
    drive(1'b1, 1'b0, OP_JAL, 3'b000, 32'hA00, 32'hB00, 1'b1, 1'b0);
    for (int k = 0; k < int'(FC); k++) begin
      step();
      chk_b($sformatf("flushwin%0d.rv", k), bus.redirect_valid, 1'b0);
      chk_b($sformatf("flushwin%0d.flush", k), bus.flush, (k < int'(FC) - 1));
      chk($sformatf("flushwin%0d.br", k), bus.br_count, 32'h1);
      chk($sformatf("flushwin%0d.mis", k), bus.mis_count, 32'h1);
    end
    idle();
    step();

    // Branch counter wraps from all-ones to zero.
    force dut.br_count_q = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, OP_BR, 3'b100, 32'hC00, 32'hD00, 1'b0, 1'b0);
    #1;
    release dut.br_count_q;
    #1;
    chk("wrap.pre", bus.br_count, 32'hFFFF_FFFF);
    step();
    chk("wrap.br", bus.br_count, 32'h0);
    chk_b("wrap.rv", bus.redirect_valid, 1'b0);
    idle();
    step();

`ifdef BHT_EN
    // Predictor training, JAL exclusion, same-cycle lookup and counter decay.
    do_reset();
    bus.id_pc = 32'h200;
    #1;
    chk_b("bht.init", bus.id_pred_taken, 1'b0);
    drive(1'b1, 1'b0, OP_JAL, 3'b000, 32'h240, 32'h300, 1'b0, 1'b0);
    step();
    idle();
    repeat (FC) step();
    chk_b("bht.jal_no_update", bus.id_pred_taken, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h200, 32'h280, 1'b1, 1'b1);
      #1;
      chk_b($sformatf("bht.pre_update%0d", k), bus.id_pred_taken, (k != 0));
      step();
      chk_b($sformatf("bht.train%0d.rv", k), bus.redirect_valid, 1'b0);
      chk_b($sformatf("bht.train%0d.pred", k), bus.id_pred_taken, 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, OP_BR, 3'b000, 32'h200, 32'h280, 1'b0, 1'b1);
      step();
      chk_b($sformatf("bht.nt%0d.rv", k), bus.redirect_valid, 1'b1);
      chk($sformatf("bht.nt%0d.rpc", k), bus.redirect_pc, 32'h204);
      idle();
      repeat (FC) step();
      chk_b($sformatf("bht.nt%0d.pred", k), bus.id_pred_taken, (k == 0));
    end
    drive(1'b1, 1'b0, OP_BR, 3'b000, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1);
    step();
    chk("bht.pc4_wrap", bus.redirect_pc, 32'h0);
    idle();
    repeat (FC) step();
`endif

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [6:0] op;
      r  = int'($urandom_range(0, 99));
      op = (r < 45) ? OP_BR : (r < 65) ? OP_JAL : OP_ALU;
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0), op,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                        : 32'($urandom_range(0, 63)) << 2,
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.id_pc = 32'($urandom_range(0, 63)) << 2;
      rst = ($urandom_range(0, 149) == 0);
      #1;
      chk_b("rnd.id_pred", bus.id_pred_taken, model_id_pred(bus.id_pc));
      model_step();
      step();
      chk_b("rnd.rv", bus.redirect_valid, m_rv);
      chk("rnd.rpc", bus.redirect_pc, m_rpc);
      chk_b("rnd.flush", bus.flush, (m_left > 0));
      chk("rnd.br", bus.br_count, m_br);
      chk("rnd.mis", bus.mis_count, m_mis);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
